// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-port instruction/data memory between the CPU port and the
// loader/debug port. Each granted access runs through a fixed-latency memory
// cycle (ACC, MEM_LAT cycles). It is followed by one DONE cycle in which the
// owner's completion pulse is raised. When both ports request at the same
// time, the port that was not served last wins, so the two ports alternate.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   cpu_memread / cpu_memwrite   CPU request levels (both high = write)
//   cpu_adr, cpu_wd              CPU address / write data
//   cpu_rd, cpu_ready            CPU read data (held), completion pulse
//   ldr_req, ldr_we              loader request level, write(1)/read(0)
//   ldr_adr, ldr_wd              loader address / write data
//   ldr_rd, ldr_ack              loader read data (held), completion pulse
//   mem_re, mem_we               memory enables, high only during ACC
//   mem_adr, mem_wd              latched address / write data
//   mem_rd                       memory read data, valid on the last ACC cycle
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1   // legal range 1..7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_ready,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_adr,
  input  logic [DW-1:0] ldr_wd,
  output logic [DW-1:0] ldr_rd,
  output logic          ldr_ack,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_cnt;
  logic          r_owner;   // 0 = CPU, 1 = loader
  logic          r_last;    // owner of the most recently completed access
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_cpu_rd;
  logic [DW-1:0] r_ldr_rd;

  logic w_cpu_req;
  logic w_grant_ldr;
  logic w_acc_end;

  assign w_cpu_req = cpu_memread | cpu_memwrite;
  // Loader wins when it is the only requester, or on a tie when the CPU was
  // served last (r_last == 0). r_last resets to 1 so the CPU wins the first tie.
  assign w_grant_ldr = ldr_req & (~w_cpu_req | ~r_last);
  assign w_acc_end   = (r_cnt == LAST_CNT);

  assign mem_adr = r_adr;
  assign mem_wd  = r_wd;
  assign cpu_rd  = r_cpu_rd;
  assign ldr_rd  = r_ldr_rd;

  // Next state and the state-decoded outputs. Because the enables and pulses
  // decode the state register directly, reset drops them immediately.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next    = r_state;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    cpu_ready = 1'b0;
    ldr_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cpu_req | ldr_req) w_next = ACC;
      end
      ACC: begin
        mem_re = ~r_we;
        mem_we = r_we;
        if (w_acc_end) w_next = DONE;
      end
      DONE: begin
        cpu_ready = ~r_owner;
        ldr_ack   = r_owner;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_wd     <= '0;
      r_cpu_rd <= '0;
      r_ldr_rd <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_cpu_req | ldr_req) begin
            r_owner <= w_grant_ldr;
            r_adr   <= w_grant_ldr ? ldr_adr : cpu_adr;
            r_wd    <= w_grant_ldr ? ldr_wd  : cpu_wd;
            // A CPU request with both memread and memwrite high is a write.
            r_we    <= w_grant_ldr ? ldr_we  : cpu_memwrite;
            r_cnt   <= 3'd0;
          end
        end
        ACC: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_acc_end) begin
            if (!r_we) begin
              if (r_owner) r_ldr_rd <= mem_rd;
              else         r_cpu_rd <= mem_rd;
            end
            r_last <= r_owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
